// File: rtl/mac_ctrl_pkg.sv
// Shared constants, element types and FSM states for the
// tile MAC engine and its weight/activation memories.
package mac_ctrl_pkg;
  localparam int TILE_SIZE  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 32;
  localparam int FRAC_BITS  = 8;
  localparam int N_BANK     = 6;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 11;
  localparam int DATA_W     = 256;
  localparam int XT_DEPTH   = 16;

  localparam int NUM_BLOCKS = N_BANK * DEPTH;
  localparam int BLK_W      = $clog2(NUM_BLOCKS);
  localparam int BANK_W     = $clog2(N_BANK);
  localparam int XA_W       = $clog2(XT_DEPTH);
  localparam int PAIR_W     = XA_W - 1;
  localparam int XT_W       = TILE_SIZE * DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  // Operand is at most one lap past the end, so one subtract suffices.
  function automatic logic [BLK_W-1:0] blk_wrap(
    input logic [BLK_W:0] k
  );
    logic [BLK_W:0] lim;
    lim = (BLK_W+1)'(NUM_BLOCKS);
    return (k >= lim) ? BLK_W'(k - lim) : BLK_W'(k);
  endfunction
endpackage

// File: rtl/wbuf_dp_bank.sv
// Banked weight buffer: one write port, two synchronous
// read ports, each selecting a bank and a line address.
module wbuf_dp_bank
  import mac_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BANK_W-1:0] a_bank,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  input  logic [BANK_W-1:0] b_bank,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);
  logic [DATA_W-1:0] mem_sim [N_BANK][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_sim[wr_bank][wr_addr] <= wr_data;
    a_data <= mem_sim[a_bank][a_addr];
    b_data <= mem_sim[b_bank][b_addr];
  end
endmodule

// File: rtl/xt_rom.sv
// Activation vector store with two synchronous read ports
// and a load port.
module xt_rom
  import mac_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [XA_W-1:0] wr_addr,
  input  logic [XT_W-1:0] wr_data,
  input  logic [XA_W-1:0] a_addr,
  output logic [XT_W-1:0] a_data,
  input  logic [XA_W-1:0] b_addr,
  output logic [XT_W-1:0] b_data
);
  logic [XT_W-1:0] mem_sim [XT_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_sim[wr_addr] <= wr_data;
    a_data <= mem_sim[a_addr];
    b_data <= mem_sim[b_addr];
  end
endmodule

// File: rtl/mac_mem_controller_combined_dp.sv
// Tile MAC engine: two weight blocks per cycle times their
// activation vectors, accumulated into one output vector.
module mac_mem_controller_combined_dp
  import mac_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic s_axis_TVALID,
  output logic s_axis_TREADY,
  output logic m_axis_TVALID,
  input  logic m_axis_TREADY,
  output logic signed [ACC_WIDTH-1:0] reduced_vec [TILE_SIZE]
);
  state_t state, state_n;

  logic [BLK_W-1:0]  ptr, ka, kb;
  logic [BLK_W:0]    k_raw;
  logic [PAIR_W-1:0] pair;
  logic [1:0]        dcnt;
  logic              rd_vld, mac_vld;
  logic              start, last_pair, drain_done;
  logic [BANK_W-1:0] a_bank, b_bank;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] wa, wb;
  logic [XT_W-1:0]   xa, xb;

  acc_t psum   [TILE_SIZE];
  acc_t psum_q [TILE_SIZE];
  acc_t acc    [TILE_SIZE];

  assign start      = (state == IDLE) && s_axis_TVALID;
  assign last_pair  = pair == PAIR_W'(XT_DEPTH/2 - 1);
  assign drain_done = dcnt == 2'd2;

  assign s_axis_TREADY = state == IDLE;
  assign m_axis_TVALID = state == OUT;

  assign k_raw  = {1'b0, ptr} + (BLK_W+1)'({pair, 1'b0});
  assign ka     = blk_wrap(k_raw);
  assign kb     = blk_wrap(k_raw + 1'b1);
  assign a_bank = BANK_W'(ka % N_BANK);
  assign a_addr = ADDR_W'(ka / N_BANK);
  assign b_bank = BANK_W'(kb % N_BANK);
  assign b_addr = ADDR_W'(kb / N_BANK);

  wbuf_dp_bank u_wbuf (
    .clk     (clk),
    .we      (1'b0),
    .wr_bank ('0),
    .wr_addr ('0),
    .wr_data ('0),
    .a_bank  (a_bank),
    .a_addr  (a_addr),
    .a_data  (wa),
    .b_bank  (b_bank),
    .b_addr  (b_addr),
    .b_data  (wb)
  );

  xt_rom u_xt (
    .clk     (clk),
    .we      (1'b0),
    .wr_addr ('0),
    .wr_data ('0),
    .a_addr  ({pair, 1'b0}),
    .a_data  (xa),
    .b_addr  ({pair, 1'b1}),
    .b_data  (xb)
  );

  always_comb begin
    for (int i = 0; i < TILE_SIZE; i++) begin
      psum[i] = '0;
      for (int c = 0; c < TILE_SIZE; c++) begin
        psum[i] = psum[i]
          + acc_t'(elem_t'(wa[(i*TILE_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]))
          * acc_t'(elem_t'(xa[c*DATA_WIDTH +: DATA_WIDTH]))
          + acc_t'(elem_t'(wb[(i*TILE_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]))
          * acc_t'(elem_t'(xb[c*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  // Drain covers read register, sum register and accumulator.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (s_axis_TVALID) state_n = ISSUE;
      ISSUE: if (last_pair)     state_n = DRAIN;
      DRAIN: if (drain_done)    state_n = OUT;
      OUT:   if (m_axis_TREADY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      pair        <= '0;
      dcnt        <= '0;
      rd_vld      <= 1'b0;
      mac_vld     <= 1'b0;
      psum_q      <= '{default: '0};
      acc         <= '{default: '0};
      reduced_vec <= '{default: '0};
    end else begin
      state   <= state_n;
      rd_vld  <= state == ISSUE;
      mac_vld <= rd_vld;
      psum_q  <= psum;
      pair    <= (state == ISSUE) ? pair + 1'b1 : '0;
      dcnt    <= (state == DRAIN) ? dcnt + 2'd1 : '0;
      if (state == ISSUE && last_pair)
        ptr <= blk_wrap({1'b0, ptr} + (BLK_W+1)'(XT_DEPTH));
      for (int i = 0; i < TILE_SIZE; i++) begin
        if (start)        acc[i] <= '0;
        else if (mac_vld) acc[i] <= acc[i] + psum_q[i];
      end
      if (state == DRAIN && drain_done)
        for (int i = 0; i < TILE_SIZE; i++)
          reduced_vec[i] <= acc[i] >>> FRAC_BITS;
    end
  end
endmodule

// File: tb/tb_mac_mem_controller_combined_dp.sv
// Bench for the tile MAC engine: fixed tiles from a table,
// abort by reset, then random tiles against a plain model.
module tb_mac_mem_controller_combined_dp;
  import mac_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_axis_TVALID = 1'b0;
  logic s_axis_TREADY;
  logic m_axis_TVALID;
  logic m_axis_TREADY = 1'b1;
  logic signed [ACC_WIDTH-1:0] reduced_vec [TILE_SIZE];

  int total = 0;
  int bad = 0;
  int mptr = 0;
  int wm [NUM_BLOCKS][TILE_SIZE*TILE_SIZE];
  int xm [XT_DEPTH][TILE_SIZE];
  int exp_v [TILE_SIZE];

  typedef struct {
    int hold;
    int expv;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  mac_mem_controller_combined_dp dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_TVALID (s_axis_TVALID),
    .s_axis_TREADY (s_axis_TREADY),
    .m_axis_TVALID (m_axis_TVALID),
    .m_axis_TREADY (m_axis_TREADY),
    .reduced_vec   (reduced_vec)
  );

  task automatic chk(input string name, input longint got,
                     input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic load_mem(input bit rnd);
    logic [DATA_W-1:0] line;
    logic [XT_W-1:0] xl;
    logic signed [DATA_WIDTH-1:0] v;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      for (int w = 0; w < TILE_SIZE*TILE_SIZE; w++) begin
        v = rnd ? 16'($urandom) : 16'(k);
        wm[k][w] = v;
        line[w*DATA_WIDTH +: DATA_WIDTH] = v;
      end
      dut.u_wbuf.mem_sim[k % N_BANK][k / N_BANK] <= line;
    end
    for (int a = 0; a < XT_DEPTH; a++) begin
      for (int c = 0; c < TILE_SIZE; c++) begin
        v = rnd ? 16'($urandom) : 16'(4*a + c + 1);
        xm[a][c] = v;
        xl[c*DATA_WIDTH +: DATA_WIDTH] = v;
      end
      dut.u_xt.mem_sim[a] <= xl;
    end
  endtask

  // Plain matrix-vector sum over the tile's wrapped block range.
  task automatic model_tile(input int p);
    int s;
    int k;
    for (int i = 0; i < TILE_SIZE; i++) begin
      s = 0;
      for (int j = 0; j < XT_DEPTH; j++) begin
        k = (p + j) % NUM_BLOCKS;
        for (int c = 0; c < TILE_SIZE; c++)
          s += wm[k][i*TILE_SIZE + c] * xm[j][c];
      end
      exp_v[i] = s >>> FRAC_BITS;
    end
  endtask

  task automatic run_tile(input int hold, input int expv);
    int lat;
    bit seen;
    model_tile(mptr);
    chk("idle_ready", s_axis_TREADY, 1);
    m_axis_TREADY = (hold == 0);
    s_axis_TVALID = 1'b1;
    @(posedge clk); #1;
    s_axis_TVALID = 1'b0;
    chk("busy_ready", s_axis_TREADY, 0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (m_axis_TVALID) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("latency", lat, 11);
    if (seen) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        chk("vec_model", reduced_vec[i], exp_v[i]);
        if (expv >= 0) chk("vec_const", reduced_vec[i], expv);
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", m_axis_TVALID, 1);
        chk("hold_ready", s_axis_TREADY, 0);
        for (int i = 0; i < TILE_SIZE; i++)
          chk("hold_vec", reduced_vec[i], exp_v[i]);
      end
      m_axis_TREADY = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", m_axis_TVALID, 0);
      chk("back_idle", s_axis_TREADY, 1);
    end
    mptr = (mptr + XT_DEPTH) % NUM_BLOCKS;
    m_axis_TREADY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    vecs[0] = '{hold: 0, expv: 82};
    vecs[1] = '{hold: 0, expv: 212};
    vecs[2] = '{hold: 3, expv: 342};
    vecs[3] = '{hold: 0, expv: 472};
    vecs[4] = '{hold: 0, expv: 75};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", s_axis_TREADY, 1);
    chk("rst_valid", m_axis_TVALID, 0);
    for (int i = 0; i < TILE_SIZE; i++)
      chk("rst_vec", reduced_vec[i], 0);

    load_mem(1'b0);
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++)
      run_tile(vecs[t].hold, vecs[t].expv);

    // Abort a tile mid-issue; the next tile restarts at block 0.
    s_axis_TVALID = 1'b1;
    @(posedge clk); #1;
    s_axis_TVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_ready", s_axis_TREADY, 1);
    chk("abort_vec", reduced_vec[0], 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_axis_TVALID) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    mptr = 0;
    run_tile(0, 82);

    load_mem(1'b1);
    @(posedge clk); #1;
    for (int t = 0; t < 6; t++)
      run_tile(int'($urandom_range(0, 3)), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
